// File: rtl/trace_session_controller.sv
// Trace session sequencer: owns the trigger/range registers, gates the per-cycle
// trace write and force-tlast strobes, and keeps saturating traced/dropped counters.
module trace_session_controller #(
  parameter int          XLEN       = 64,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 64,
  parameter logic [31:0] WFI_INSTR  = 32'h00000001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                  ctrl_write_enable,
  input  logic [XLEN-1:0]       pc,
  input  logic [31:0]           instr,
  input  logic                  pc_valid,
  input  logic                  fifo_ready,
  output logic                  trace_write_enable,
  output logic                  force_tlast,
  output logic [1:0]            session_state,
  output logic [31:0]           trace_count,
  output logic [31:0]           dropped_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_TRACING = 2'd2,
    S_STOPPED = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_START_EN   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_END_EN     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_START_ADDR = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_END_ADDR   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_LO_EN      = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_HI_EN      = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_LO_BOUND   = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] A_HI_BOUND   = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] A_COMMAND    = ADDR_WIDTH'(9);
  localparam logic [ADDR_WIDTH-1:0] A_CLEAR      = ADDR_WIDTH'(10);

  state_t          state_q, state_d;
  logic            start_en, end_en, lo_en, hi_en;
  logic [XLEN-1:0] start_addr, end_addr, lo_bound, hi_bound;
  logic [31:0]     trace_cnt_q, dropped_cnt_q;

  logic [XLEN-1:0] wdata_x;
  logic            cmd_write, arm, disarm, clear;
  logic            in_range, start_hit, end_hit, wfi_hit;
  logic            active, would_write, stop_event;

  assign wdata_x   = XLEN'(ctrl_wdata);
  assign cmd_write = ctrl_write_enable & (ctrl_addr == A_COMMAND);
  assign arm       = cmd_write & ctrl_wdata[0];
  assign disarm    = cmd_write & ~ctrl_wdata[0];
  assign clear     = (ctrl_write_enable & (ctrl_addr == A_CLEAR)) | arm;

  // Triggers look at the raw pc; only the write itself is range-gated.
  assign in_range    = (~lo_en | (pc >= lo_bound)) & (~hi_en | (pc <= hi_bound));
  assign start_hit   = pc_valid & start_en & (pc == start_addr);
  assign end_hit     = pc_valid & end_en & (pc == end_addr);
  assign wfi_hit     = pc_valid & (instr == WFI_INSTR);
  assign active      = (state_q == S_TRACING) | ((state_q == S_ARMED) & start_hit);
  assign would_write = pc_valid & in_range & active;
  assign stop_event  = active & (end_hit | wfi_hit);

  assign trace_write_enable = would_write & fifo_ready;
  assign force_tlast        = stop_event & trace_write_enable;
  assign session_state      = state_q;
  assign trace_count        = trace_cnt_q;
  assign dropped_count      = dropped_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_en   <= 1'b0;
      end_en     <= 1'b0;
      lo_en      <= 1'b0;
      hi_en      <= 1'b0;
      start_addr <= '0;
      end_addr   <= '1;
      lo_bound   <= '0;
      hi_bound   <= '1;
    end else if (ctrl_write_enable) begin
      case (ctrl_addr)
        A_START_EN:   start_en   <= ctrl_wdata[0];
        A_END_EN:     end_en     <= ctrl_wdata[0];
        A_START_ADDR: start_addr <= wdata_x;
        A_END_ADDR:   end_addr   <= wdata_x;
        A_LO_EN:      lo_en      <= ctrl_wdata[0];
        A_HI_EN:      hi_en      <= ctrl_wdata[0];
        A_LO_BOUND:   lo_bound   <= wdata_x;
        A_HI_BOUND:   hi_bound   <= wdata_x;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // A command write wins over any trigger seen in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARMED: begin
        if (stop_event)     state_d = S_STOPPED;
        else if (start_hit) state_d = S_TRACING;
      end
      S_TRACING: if (stop_event) state_d = S_STOPPED;
      default: ;
    endcase
    if (disarm)   state_d = S_IDLE;
    else if (arm) state_d = start_en ? S_ARMED : S_TRACING;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_cnt_q   <= '0;
      dropped_cnt_q <= '0;
    end else if (clear) begin
      trace_cnt_q   <= '0;
      dropped_cnt_q <= '0;
    end else begin
      if (trace_write_enable && trace_cnt_q != 32'hFFFFFFFF)
        trace_cnt_q <= trace_cnt_q + 32'd1;
      if (would_write && !fifo_ready && dropped_cnt_q != 32'hFFFFFFFF)
        dropped_cnt_q <= dropped_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_trace_session_controller.sv
// Directed plus randomized bench for trace_session_controller, checked against a
// session-level reference model evaluated once per cycle.
module tb_trace_session_controller;

  localparam int IDLE = 0, ARMED = 1, TRACING = 2, STOPPED = 3;
  localparam logic [63:0] SAT = 64'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ctrl_addr = '0;
  logic [63:0] ctrl_wdata = '0;
  logic        ctrl_write_enable = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instr = '0;
  logic        pc_valid = 1'b0;
  logic        fifo_ready = 1'b0;
  logic        trace_write_enable, force_tlast;
  logic [1:0]  session_state;
  logic [31:0] trace_count, dropped_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_state;
  bit          m_start_en, m_end_en, m_lo_en, m_hi_en;
  logic [63:0] m_start_addr, m_end_addr, m_lo, m_hi;
  logic [63:0] m_tc, m_dc;

  trace_session_controller dut (
    .clk(clk), .rst(rst), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .pc(pc), .instr(instr),
    .pc_valid(pc_valid), .fifo_ready(fifo_ready),
    .trace_write_enable(trace_write_enable), .force_tlast(force_tlast),
    .session_state(session_state), .trace_count(trace_count),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_state = IDLE;
    m_start_en = 0; m_end_en = 0; m_lo_en = 0; m_hi_en = 0;
    m_start_addr = '0; m_end_addr = '1; m_lo = '0; m_hi = '1;
    m_tc = 0; m_dc = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit we, input int addr, input logic [63:0] wd,
                               input bit pv, input logic [63:0] p, input logic [31:0] ins,
                               input bit fr);
    bit inr, sh, eh, wh, act, ww, twe, stp, arm_c, dis_c, clr_c;
    ctrl_write_enable = we; ctrl_addr = 8'(addr); ctrl_wdata = wd;
    pc_valid = pv; pc = p; instr = ins; fifo_ready = fr;

    inr = (!m_lo_en || p >= m_lo) && (!m_hi_en || p <= m_hi);
    sh  = pv && m_start_en && p == m_start_addr;
    eh  = pv && m_end_en && p == m_end_addr;
    wh  = pv && ins == 32'h00000001;
    act = m_state == TRACING || (m_state == ARMED && sh);
    ww  = pv && inr && act;
    twe = ww && fr;
    stp = act && (eh || wh);
    arm_c = we && addr == 9 && wd[0];
    dis_c = we && addr == 9 && !wd[0];
    clr_c = (we && addr == 10) || arm_c;

    @(negedge clk);
    checkOutput("trace_write_enable", 64'(trace_write_enable), 64'(twe));
    checkOutput("force_tlast", 64'(force_tlast), 64'(stp && twe));
    checkOutput("session_state", 64'(session_state), 64'(m_state));
    checkOutput("trace_count", 64'(trace_count), m_tc);
    checkOutput("dropped_count", 64'(dropped_count), m_dc);

    @(posedge clk);
    if (clr_c) begin
      m_tc = 0; m_dc = 0;
    end else begin
      if (twe && m_tc < SAT) m_tc = m_tc + 1;
      if (ww && !fr && m_dc < SAT) m_dc = m_dc + 1;
    end
    if (dis_c) m_state = IDLE;
    else if (arm_c) m_state = m_start_en ? ARMED : TRACING;
    else if (stp) m_state = STOPPED;
    else if (m_state == ARMED && sh) m_state = TRACING;
    if (we) begin
      case (addr)
        0: m_start_en = wd[0];
        1: m_end_en = wd[0];
        2: m_start_addr = wd;
        3: m_end_addr = wd;
        4: m_lo_en = wd[0];
        5: m_hi_en = wd[0];
        6: m_lo = wd;
        7: m_hi = wd;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic regWrite(input int addr, input logic [63:0] wd);
    applyStimulus(1, addr, wd, 0, 64'h0, 32'h13, 1);
  endtask

  task automatic feed(input logic [63:0] p, input logic [31:0] ins, input bit fr);
    applyStimulus(0, 0, 64'h0, 1, p, ins, fr);
  endtask

  task automatic doReset();
    ctrl_write_enable = 0; pc_valid = 0; fifo_ready = 0;
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    modelReset();
    @(posedge clk); #1;
  endtask

  initial begin
    int op;
    logic [63:0] rp;
    modelReset();
    #12;
    doReset();

    // reset state
    applyStimulus(0, 0, 64'h0, 1, 64'h100, 32'h13, 1);

    // ARM with start disabled: trace pc 0x100..0x10C
    regWrite(9, 64'h1);
    for (int i = 0; i < 4; i++) feed(64'h100 + 64'(4 * i), 32'h13, 1);
    checkOutput("plan1_count", 64'(trace_count), 64'd4);
    checkOutput("plan1_state", 64'(session_state), 64'(TRACING));

    // start trigger at 0x200
    regWrite(0, 64'h1);
    regWrite(2, 64'h200);
    regWrite(9, 64'h1);
    feed(64'h1F8, 32'h13, 1);
    feed(64'h1FC, 32'h13, 1);
    checkOutput("plan2_armed", 64'(session_state), 64'(ARMED));
    feed(64'h200, 32'h13, 1);
    feed(64'h204, 32'h13, 1);
    checkOutput("plan2_count", 64'(trace_count), 64'd2);

    // end trigger at 0x300
    regWrite(1, 64'h1);
    regWrite(3, 64'h300);
    feed(64'h2FC, 32'h13, 1);
    feed(64'h300, 32'h13, 1);
    checkOutput("plan3_stopped", 64'(session_state), 64'(STOPPED));
    feed(64'h304, 32'h13, 1);
    checkOutput("plan3_count", 64'(trace_count), 64'd4);

    // range window 0x400..0x40F
    regWrite(0, 64'h0);
    regWrite(9, 64'h1);
    regWrite(4, 64'h1);
    regWrite(5, 64'h1);
    regWrite(6, 64'h400);
    regWrite(7, 64'h40F);
    feed(64'h3FC, 32'h13, 1);
    feed(64'h400, 32'h13, 1);
    feed(64'h40C, 32'h13, 1);
    feed(64'h410, 32'h13, 1);
    checkOutput("plan4_count", 64'(trace_count), 64'd2);

    // WFI under backpressure
    feed(64'h404, 32'h00000001, 0);
    checkOutput("plan5_dropped", 64'(dropped_count), 64'd1);
    checkOutput("plan5_stopped", 64'(session_state), 64'(STOPPED));

    // asynchronous reset mid-session
    regWrite(4, 64'h0);
    regWrite(5, 64'h0);
    regWrite(9, 64'h1);
    ctrl_write_enable = 0; pc_valid = 1; pc = 64'h600; instr = 32'h13; fifo_ready = 1;
    #2;
    checkOutput("async_pre_twe", 64'(trace_write_enable), 64'd1);
    rst = 1;
    #1;
    checkOutput("async_twe", 64'(trace_write_enable), 64'd0);
    checkOutput("async_state", 64'(session_state), 64'(IDLE));
    doReset();

    // trace_count saturation
    regWrite(9, 64'h1);
    feed(64'h700, 32'h13, 1);
    force dut.trace_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.trace_cnt_q;
    m_tc = SAT;
    feed(64'h704, 32'h13, 1);
    checkOutput("sat_count", 64'(trace_count), SAT);
    feed(64'h708, 32'h13, 1);

    // randomized traffic around the programmed addresses
    regWrite(2, 64'h800);
    regWrite(3, 64'h840);
    regWrite(6, 64'h810);
    regWrite(7, 64'h830);
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0: rp = 64'h800 + 64'(4 * $urandom_range(0, 20));
        1: rp = 64'h800;
        2: rp = 64'h840;
        default: rp = 64'({$urandom, $urandom});
      endcase
      if (op < 8)
        applyStimulus(1, 9, 64'($urandom_range(0, 1)), $urandom_range(0, 1), rp, 32'h13, 1);
      else if (op < 12)
        applyStimulus(1, 10, 64'h0, 1, rp, 32'h13, 1);
      else if (op < 20)
        applyStimulus(1, int'($urandom_range(0, 11)), 64'($urandom_range(0, 1)), 1, rp,
                      32'h13, $urandom_range(0, 1));
      else
        applyStimulus(0, 0, 64'h0, $urandom_range(0, 3) != 0, rp,
                      ($urandom_range(0, 19) == 0) ? 32'h00000001 : 32'h13,
                      $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_session_controller.md
Name: trace_session_controller

Overview:
- Sequences one trace session for the continuous monitoring datapath: arm, wait for start trigger, trace, stop on end trigger or WFI.
- Owns the trigger and monitored-range registers, written through the ctrl address/data bus.
- Produces the per-cycle write enable and force-tlast strobes that drive the trace FIFO / AXI-stream packer.
- Keeps saturating counters of traced and dropped packets.

Parameters:
- XLEN, 64, pc width.
- ADDR_WIDTH, 8, ctrl address width.
- DATA_WIDTH, 64, ctrl write-data width.
- WFI_INSTR, 32'h00000001, instruction encoding that ends a session.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_addr  in  ADDR_WIDTH  register address.
- ctrl_wdata  in  DATA_WIDTH  register write data.
- ctrl_write_enable  in  1  level write strobe; a write occurs on every cycle it is high.
- pc  in  XLEN  retired program counter.
- instr  in  32  retired instruction.
- pc_valid  in  1  pc/instr valid this cycle.
- fifo_ready  in  1  downstream can accept a packet this cycle.
- trace_write_enable  out  1  write {pc,instr} this cycle.
- force_tlast  out  1  close the current AXI packet with this write.
- session_state  out  2  0 IDLE, 1 ARMED, 2 TRACING, 3 STOPPED.
- trace_count  out  32  packets written.
- dropped_count  out  32  packets lost to backpressure.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE; both counters 0; all *_en registers 0.
  - start_addr and lo_bound 0; end_addr and hi_bound all-ones.
  - trace_write_enable and force_tlast 0.
- Register map (write-only; only the low bits needed by each register are used):
  - 0 start_en, 1 end_en, 2 start_addr, 3 end_addr.
  - 4 lo_en, 5 hi_en, 6 lo_bound, 7 hi_bound.
  - 9 command: wdata[0]=1 ARM, wdata[0]=0 DISARM.
  - 10 clear counters.
  - Writes to any other address are ignored.
- Register writes take effect the cycle after the write.
- in_range = (~lo_en | pc>=lo_bound) & (~hi_en | pc<=hi_bound), unsigned compare.
- start_hit = pc_valid & start_en & (pc==start_addr).
- end_hit = pc_valid & end_en & (pc==end_addr).
- wfi_hit = pc_valid & (instr==WFI_INSTR).
- would_write = pc_valid & in_range & (state==TRACING | (state==ARMED & start_hit)).
- trace_write_enable = would_write & fifo_ready. This path is combinational, zero latency.
- stop_event = (state==TRACING | (state==ARMED & start_hit)) & (end_hit | wfi_hit).
- force_tlast = stop_event & trace_write_enable.
- FSM transitions, registered, next cycle:
  - IDLE: ARM -> TRACING if start_en=0, else ARMED.
  - ARMED: stop_event -> STOPPED; else start_hit -> TRACING. The triggering instruction is itself eligible for trace.
  - TRACING: stop_event -> STOPPED. The stopping instruction is traced if in range and fifo_ready.
  - STOPPED: no tracing; ARM re-enters exactly as from IDLE.
  - DISARM in any state -> IDLE.
  - A command write in the same cycle as a trigger overrides the trigger's transition. Outputs in that cycle still follow the current state.
- Counters:
  - ARM clears both counters.
  - trace_count +1 per trace_write_enable; saturates at 32'hFFFFFFFF.
  - dropped_count +1 per cycle with would_write & ~fifo_ready; saturates.
  - Clear (addr 10 or ARM) coinciding with an increment yields 0.
- Triggers ignore in_range; only the write is gated by the range.
- Reset mid-session returns to IDLE immediately, asynchronously. Outputs go low without waiting for clk.

Test Plan:
- Reset then write ARM (addr 9, wdata 1) with start_en=0. Feed pc 0x100..0x10C, pc_valid=1, fifo_ready=1 -> state TRACING from the next cycle, 4 writes, trace_count=4.
- start_en=1, start_addr=0x200, ARM. Feed pc 0x1F8, 0x1FC, 0x200, 0x204 -> no writes before 0x200; writes at 0x200 and 0x204; state ARMED then TRACING.
- end_en=1, end_addr=0x300 while TRACING. Feed pc 0x2FC, 0x300 -> write at 0x300 with force_tlast=1; STOPPED next cycle; pc 0x304 not written.
- lo_en=hi_en=1, lo=0x400, hi=0x40F while TRACING. Feed pc 0x3FC, 0x400, 0x40C, 0x410 -> writes only at 0x400 and 0x40C.
- While TRACING, instr=0x00000001 with fifo_ready=0 -> trace_write_enable=0, force_tlast=0, dropped_count +1, STOPPED next cycle.
- Assert rst mid-TRACING between clock edges -> trace_write_enable drops at once, state IDLE. Force trace_count to 32'hFFFFFFFF, then one more write -> count stays at 32'hFFFFFFFF.
